// File: rtl/food_eat_controller.sv
// Food-box placement requester for the Snake game.
// Validates generator positions, detects eating, keeps a BCD score.
module food_eat_controller #(
   parameter int BOX       = 8,
   parameter int FIELD_W   = 640,
   parameter int FIELD_H   = 480,
   parameter int SETTLE    = 3,
   parameter int MAX_RETRY = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic [9:0] head_x,
   input  logic [8:0] head_y,
   input  logic [9:0] x_box,
   input  logic [8:0] y_box,
   output logic       create_new_box,
   output logic       box_ready,
   output logic       eat,
   output logic       grow,
   output logic [7:0] score_bcd,
   output logic [3:0] retry_cnt
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_CHECK,
      S_READY
   } state_t;

   localparam logic [9:0]  BOX_X  = 10'(BOX);
   localparam logic [8:0]  BOX_Y  = 9'(BOX);
   localparam logic [10:0] LIM_X  = 11'(FIELD_W);
   localparam logic [9:0]  LIM_Y  = 10'(FIELD_H);
   localparam logic [7:0]  CNT_LD = 8'(SETTLE - 1);
   localparam logic [3:0]  RT_MAX = 4'(MAX_RETRY);

   state_t     r_state, w_state;
   logic [7:0] r_cnt, w_cnt;
   logic [9:0] r_hx, w_hx;
   logic [8:0] r_hy, w_hy;
   logic [9:0] r_bx, w_bx;
   logic [8:0] r_by, w_by;
   logic       r_cnb, w_cnb;
   logic       r_rdy, w_rdy;
   logic       r_eat, w_eat;
   logic [7:0] r_score, w_score;
   logic [3:0] r_retry, w_retry;

   logic       w_in_field;
   logic       w_head_hit;
   logic       w_legal;
   logic       w_eat_hit;
   logic [7:0] w_score_inc;

   // Tiles overlap when both axis distances are below one tile edge.
   function automatic logic overlap(
      input logic [9:0] ax,
      input logic [9:0] bx,
      input logic [8:0] ay,
      input logic [8:0] by
   );
      logic [9:0] dx;
      logic [8:0] dy;
      dx = (ax >= bx) ? (ax - bx) : (bx - ax);
      dy = (ay >= by) ? (ay - by) : (by - ay);
      return (dx < BOX_X) && (dy < BOX_Y);
   endfunction

   // Legality of the generator position and eat detection on a tick.
   always_comb begin
      w_in_field = (({1'b0, x_box} + 11'(BOX)) <= LIM_X) &&
                   (({1'b0, y_box} + 10'(BOX)) <= LIM_Y);
      w_head_hit = overlap(x_box, r_hx, y_box, r_hy);
      w_legal    = w_in_field && !w_head_hit;
      w_eat_hit  = tick && overlap(head_x, r_bx, head_y, r_by);
   end

   // Saturating two-digit BCD increment.
   always_comb begin
      w_score_inc = r_score;
      if (r_score == 8'h99)
         w_score_inc = r_score;
      else if (r_score[3:0] == 4'd9)
         w_score_inc = {r_score[7:4] + 4'd1, 4'd0};
      else
         w_score_inc = {r_score[7:4], r_score[3:0] + 4'd1};
   end

   // Next-state and next-output logic for the placement FSM.
   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_hx    = tick ? head_x : r_hx;
      w_hy    = tick ? head_y : r_hy;
      w_bx    = r_bx;
      w_by    = r_by;
      w_cnb   = 1'b0;
      w_rdy   = r_rdy;
      w_eat   = 1'b0;
      w_score = r_score;
      w_retry = r_retry;
      unique case (r_state)
         S_REQ: begin
            w_cnb   = 1'b1;
            w_cnt   = CNT_LD;
            w_state = S_WAIT;
         end
         S_WAIT: begin
            if (r_cnt == 8'd0)
               w_state = S_CHECK;
            else
               w_cnt = r_cnt - 8'd1;
         end
         S_CHECK: begin
            w_bx = x_box;
            w_by = y_box;
            if (w_legal || (r_retry >= RT_MAX)) begin
               w_rdy   = 1'b1;
               w_state = S_READY;
            end else begin
               w_retry = r_retry + 4'd1;
               w_state = S_REQ;
            end
         end
         S_READY: begin
            if (w_eat_hit) begin
               w_eat   = 1'b1;
               w_score = w_score_inc;
               w_rdy   = 1'b0;
               w_retry = 4'd0;
               w_state = S_REQ;
            end
         end
         default: w_state = S_REQ;
      endcase
   end

   // State and registered outputs; reset aborts any placement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_REQ;
         r_cnt   <= 8'd0;
         r_hx    <= 10'd0;
         r_hy    <= 9'd0;
         r_bx    <= 10'd0;
         r_by    <= 9'd0;
         r_cnb   <= 1'b0;
         r_rdy   <= 1'b0;
         r_eat   <= 1'b0;
         r_score <= 8'h00;
         r_retry <= 4'd0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_hx    <= w_hx;
         r_hy    <= w_hy;
         r_bx    <= w_bx;
         r_by    <= w_by;
         r_cnb   <= w_cnb;
         r_rdy   <= w_rdy;
         r_eat   <= w_eat;
         r_score <= w_score;
         r_retry <= w_retry;
      end
   end

   assign create_new_box = r_cnb;
   assign box_ready      = r_rdy;
   assign eat            = r_eat;
   assign grow           = r_eat;
   assign score_bcd      = r_score;
   assign retry_cnt      = r_retry;

endmodule
